// File: rtl/bram1_be_rsp.sv
// Single-port byte-enabled block RAM with valid/ready requests and a
// credit-tracked response FIFO, so a stalled consumer never loses read data.

module bram1_be_lane #(
  parameter int ADDR_WIDTH  = 10,
  parameter int BYTE_WIDTH  = 8,
  parameter int MEMSIZE     = 1024,
  parameter int WRITE_FIRST = 0
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [BYTE_WIDTH-1:0] di,
  output logic [BYTE_WIDTH-1:0] dout
);
  localparam logic [ADDR_WIDTH:0] MSZ = (ADDR_WIDTH+1)'(MEMSIZE);

  logic [BYTE_WIDTH-1:0] mem [MEMSIZE];
  logic                  in_range;

  assign in_range = {1'b0, addr} < MSZ;

  // A disabled lane always reads back its stored byte, so the write-first
  // word is the byte-merged result without a separate merge mux.
  always_ff @(posedge clk) begin
    if (we && in_range) mem[addr] <= di;
    if (WRITE_FIRST != 0 && we) dout <= di;
    else                        dout <= mem[addr];
  end
endmodule

module bram1_be_rsp #(
  parameter int ADDR_WIDTH    = 10,
  parameter int DATA_WIDTH    = 32,
  parameter int BYTE_WIDTH    = 8,
  parameter int MEMSIZE       = 1024,
  parameter int PIPELINED     = 0,
  parameter int WRITE_FIRST   = 0,
  parameter int RESP_ON_WRITE = 0,
  parameter int RESP_DEPTH    = 4
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             REQ_VALID,
  output logic                             REQ_RDY,
  input  logic                             REQ_WE,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] REQ_BE,
  input  logic [ADDR_WIDTH-1:0]            REQ_ADDR,
  input  logic [DATA_WIDTH-1:0]            REQ_DI,
  output logic                             RSP_VALID,
  input  logic                             RSP_RDY,
  output logic [DATA_WIDTH-1:0]            RSP_DO,
  output logic [$clog2(RESP_DEPTH):0]      RSP_CNT
);
  localparam int NUM_LANES = DATA_WIDTH / BYTE_WIDTH;
  localparam int STAGES    = (PIPELINED != 0) ? 2 : 1;
  localparam int PW        = $clog2(RESP_DEPTH);
  localparam int CW        = PW + 1;

  typedef struct packed {
    logic                            we;
    logic [NUM_LANES-1:0]            be;
    logic [ADDR_WIDTH-1:0]           addr;
    logic [NUM_LANES-1:0][BYTE_WIDTH-1:0] di;
  } req_t;

  req_t                                 req;
  logic                                 fire, need_rsp, push, pop, empty;
  logic [STAGES:0]                      vld_pipe;
  logic [STAGES-1:0]                    vld_q;
  logic [NUM_LANES-1:0][BYTE_WIDTH-1:0] ram_q;
  logic [DATA_WIDTH-1:0]                stage_d;
  logic [CW-1:0]                        cnt;
  logic [PW:0]                          wptr, rptr;
  logic [DATA_WIDTH-1:0]                fifo [RESP_DEPTH];

  assign req.we   = REQ_WE;
  assign req.be   = REQ_BE;
  assign req.addr = REQ_ADDR;
  assign req.di   = REQ_DI;

  // Credit check covers in-flight reads, so a push always has a free slot.
  assign REQ_RDY  = !RST && (cnt < CW'(RESP_DEPTH));
  assign fire     = REQ_VALID && REQ_RDY;
  assign need_rsp = !req.we || (RESP_ON_WRITE != 0);

  always_comb vld_pipe = {vld_q, fire && need_rsp};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    bram1_be_lane #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .BYTE_WIDTH (BYTE_WIDTH),
      .MEMSIZE    (MEMSIZE),
      .WRITE_FIRST(WRITE_FIRST)
    ) u_lane (
      .clk (CLK),
      .we  (fire && req.we && req.be[i]),
      .addr(req.addr),
      .di  (req.di[i]),
      .dout(ram_q[i])
    );
  end

  if (PIPELINED != 0) begin : g_pipe
    logic [DATA_WIDTH-1:0] out_q;
    always_ff @(posedge CLK) out_q <= ram_q;
    assign stage_d = out_q;
  end else begin : g_nopipe
    assign stage_d = ram_q;
  end

  assign push      = vld_pipe[STAGES];
  assign empty     = (wptr == rptr);
  assign RSP_VALID = !empty;
  assign pop       = RSP_VALID && RSP_RDY;
  assign RSP_DO    = empty ? '0 : fifo[rptr[PW-1:0]];
  assign RSP_CNT   = cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_q <= '0;
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
    end else begin
      vld_q <= vld_pipe[STAGES-1:0];
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({vld_pipe[0], pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) fifo[wptr[PW-1:0]] <= stage_d;
  end
endmodule
